// File: rtl/ibex_fetch_prefetch_unit.sv
// ibex_fetch_prefetch_unit: word prefetcher with outstanding-request tracking, response FIFO and halfword realignment
module ibex_fetch_prefetch_unit #(
    parameter int unsigned FifoDepth      = 3,
    parameter int unsigned NumOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        err_plus2_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_pmp_err_i,
    output logic        busy_o
);
    localparam int unsigned CW = $clog2(FifoDepth + 1);
    localparam int unsigned OW = $clog2(NumOutstanding + 1);

    logic          started_q, started_d;
    logic          pmp_block_q, pmp_block_d;
    logic          pmp_pend_q, pmp_pend_d;
    logic          offset_q, offset_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   addr_q, addr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d, count_pop;
    logic [31:0]   data_q [FifoDepth];
    logic [31:0]   data_d [FifoDepth];
    logic          err_q [FifoDepth];
    logic          err_d [FifoDepth];
    logic          req, pmp_take, bus_gnt, drop, push, v1, e1, comp, valid, err, fire, is_c, pop;

    always_comb begin
        req = req_i & (started_q | branch_i) & (branch_i | ~pmp_block_q)
            & (32'(outstanding_q) + 32'(count_q) + 32'(pmp_pend_q) < FifoDepth)
            & (32'(outstanding_q) < NumOutstanding);
        pmp_take = req & instr_pmp_err_i & (outstanding_q == '0);
        bus_gnt = req & instr_gnt_i & ~instr_pmp_err_i;
        drop = instr_rvalid_i & (discard_q != '0);
        push = ~branch_i & ((instr_rvalid_i & ~drop) | pmp_pend_q);
        v1 = count_q > CW'(1);
        e1 = err_q[1] & v1;
        comp = offset_q ? (data_q[0][17:16] != 2'b11) : (data_q[0][1:0] != 2'b11);
        valid = ~branch_i & (count_q != '0) & (~offset_q | comp | err_q[0] | v1);
        err = offset_q ? (err_q[0] | (~comp & e1)) : err_q[0];
        fire = valid & ready_i;
        is_c = comp & ~err;
        pop = fire & (offset_q | ~is_c);
        started_d = started_q | branch_i;
        pmp_block_d = (pmp_block_q & ~branch_i) | pmp_take;
        pmp_pend_d = pmp_take;
        outstanding_d = outstanding_q + OW'(bus_gnt) - OW'(instr_rvalid_i);
        discard_d = branch_i ? outstanding_q - OW'(instr_rvalid_i) : discard_q - OW'(drop);
        fetch_addr_d = (branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q) + ((bus_gnt | pmp_take) ? 32'd4 : 32'd0);
        offset_d = branch_i ? addr_i[1] : fire ? (offset_q ? ~is_c : is_c) : offset_q;
        addr_d = branch_i ? addr_i : fire ? addr_q + (is_c ? 32'd2 : 32'd4) : addr_q;
        count_pop = count_q - CW'(pop);
        count_d = branch_i ? '0 : count_pop + CW'(push);
        data_d = data_q;
        err_d = err_q;
        for (int i = 0; i < FifoDepth - 1; i++) begin
            data_d[i] = pop ? data_q[i + 1] : data_q[i];
            err_d[i] = pop ? err_q[i + 1] : err_q[i];
        end
        for (int i = 0; i < FifoDepth; i++) begin
            if (push && count_pop == CW'(i)) begin
                data_d[i] = pmp_pend_q ? 32'h0 : instr_rdata_i;
                err_d[i] = pmp_pend_q | instr_err_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            started_q <= 1'b0;
            pmp_block_q <= 1'b0;
            pmp_pend_q <= 1'b0;
            offset_q <= 1'b0;
            fetch_addr_q <= '0;
            addr_q <= '0;
            outstanding_q <= '0;
            discard_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                data_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            started_q <= started_d;
            pmp_block_q <= pmp_block_d;
            pmp_pend_q <= pmp_pend_d;
            offset_q <= offset_d;
            fetch_addr_q <= fetch_addr_d;
            addr_q <= addr_d;
            outstanding_q <= outstanding_d;
            discard_q <= discard_d;
            count_q <= count_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end

    assign instr_req_o = req;
    assign instr_addr_o = branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q;
    assign valid_o = valid;
    assign rdata_o = offset_q ? {data_q[1][15:0], data_q[0][31:16]} : data_q[0];
    assign addr_o = addr_q;
    assign err_o = err;
    assign err_plus2_o = offset_q & ~comp & e1 & ~err_q[0];
    assign busy_o = req | (outstanding_q != '0);
endmodule
